// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Purpose : Shared definitions for the instruction-memory loader. Provides
//           the default store depth, the loader state encoding and the byte
//           lane indices used by the word assembler.
// Config  : IMEM_LOADER_CHECKSUM_EN adds the CHK state to the encoding.
// Revision: 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Default depth of the instruction store, in 32-bit words.
  localparam logic [31:0] IMEM_ROWS = 32'h0000_0200;

  // Byte-address step between consecutive instruction words.
  localparam logic [31:0] ADDR_STEP = 32'd4;

  // Byte lane indices inside a little-endian 32-bit word.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  // Loader states, explicitly encoded in 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK    = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } imem_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : imem_word_assembler
// Purpose : Packs a byte stream into little-endian 32-bit words. The first
//           byte of each group lands in bits [7:0], the fourth in [31:24].
//           When the fourth byte is taken the full word is registered and a
//           one-cycle word_ready pulse follows in the next cycle.
// Ports   : clk        - system clock
//           rst_n      - asynchronous active-low reset
//           clr        - synchronous restart of the byte index
//           byte_in    - incoming stream byte
//           byte_take  - byte_in is consumed on this rising edge
//           last_lane  - byte being taken completes a word (combinational)
//           word_out   - last completed word
//           word_ready - one-cycle pulse, word_out freshly updated
// Revision: 1.0 - initial release
// ============================================================================
module imem_word_assembler
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_take,
  output logic        last_lane,
  output logic [31:0] word_out,
  output logic        word_ready
);

  logic [1:0]  r_idx;
  logic [23:0] r_lanes;
  logic [31:0] r_word;
  logic        r_ready;

  assign last_lane  = byte_take && (r_idx == LANE_B3);
  assign word_out   = r_word;
  assign word_ready = r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= LANE_B0;
      r_lanes <= 24'd0;
      r_word  <= 32'd0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (clr) begin
        r_idx <= LANE_B0;
      end else if (byte_take) begin
        case (r_idx)
          LANE_B0: r_lanes[7:0]   <= byte_in;
          LANE_B1: r_lanes[15:8]  <= byte_in;
          LANE_B2: r_lanes[23:16] <= byte_in;
          LANE_B3: begin
            // Lower three lanes are already held; splice in the top byte.
            r_word  <= {byte_in, r_lanes};
            r_ready <= 1'b1;
          end
        endcase
        r_idx <= r_idx + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Purpose : Instruction-memory program loader. Receives a byte stream
//           (2-byte little-endian word count N, then N little-endian words),
//           writes each word to sequential word addresses from 0, and holds
//           the core in reset until the load completes.
// Config  : IMEM_LOADER_CHECKSUM_EN - a trailing XOR checksum byte over all
//           data bytes is expected and verified before DONE.
// Ports   : clk        - system clock
//           reset_n    - asynchronous active-low reset
//           start      - one-cycle pulse, begins a load from IDLE/DONE/ERROR
//           byte_in    - stream byte
//           byte_valid - byte_in valid this cycle
//           byte_ready - loader accepts byte_in
//           wr_en      - one-cycle instruction-memory write strobe
//           wr_addr    - word-aligned byte address of the write
//           wr_data    - assembled instruction word
//           cpu_hold   - holds the core in reset while high
//           done       - load completed successfully (level)
//           error      - load aborted (level)
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter logic [31:0] ROWS = IMEM_ROWS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  imem_state_e r_state;
  imem_state_e w_state_next;

  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [31:0] r_wr_addr;

  logic        w_xfer;
  logic        w_launch;
  logic        w_data_take;
  logic        w_last_lane;
  logic        w_final_word;
  logic [15:0] w_len_full;
  logic        w_len_too_big;
  logic        w_word_ready;
  logic [31:0] w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  assign w_xfer      = byte_valid && byte_ready;
  assign w_data_take = w_xfer && (r_state == ST_DATA);
  assign w_launch    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));

  // Full count as seen during the LEN_HI transfer, before it is registered.
  assign w_len_full    = {byte_in, r_len[7:0]};
  assign w_len_too_big = ({16'd0, w_len_full} > ROWS);

  // The word counter still holds the index of the word being completed.
  assign w_final_word  = w_last_lane && ((r_word_cnt + 16'd1) == r_len);

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (reset_n),
    .clr        (w_launch),
    .byte_in    (byte_in),
    .byte_take  (w_data_take),
    .last_lane  (w_last_lane),
    .word_out   (w_word),
    .word_ready (w_word_ready)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) w_state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_xfer) w_state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_xfer) begin
          if (w_len_too_big) begin
            w_state_next = ST_ERROR;
          end else if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state_next = ST_CHK;
`else
            w_state_next = ST_DONE;
`endif
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // The write strobe for this last word fires in the next cycle from
        // the assembler, independent of the state that follows.
        if (w_final_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = ST_CHK;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_xfer) w_state_next = (byte_in == r_csum) ? ST_DONE : ST_ERROR;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK:                        byte_ready = 1'b1;
`endif
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Length, word counter, write address and checksum
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len      <= 16'd0;
      r_word_cnt <= 16'd0;
      r_wr_addr  <= 32'd0;
    end else if (w_launch) begin
      // A launch can coincide with the final strobe of the previous load;
      // the restart wins so the new load begins at address 0.
      r_len      <= 16'd0;
      r_word_cnt <= 16'd0;
      r_wr_addr  <= 32'd0;
    end else begin
      if (w_xfer && (r_state == ST_LEN_LO)) r_len[7:0]  <= byte_in;
      if (w_xfer && (r_state == ST_LEN_HI)) r_len[15:8] <= byte_in;
      if (w_last_lane)                      r_word_cnt  <= r_word_cnt + 16'd1;
      // Advance only after the strobe so wr_addr is stable during it.
      if (w_word_ready)                     r_wr_addr   <= r_wr_addr + ADDR_STEP;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= 8'd0;
    end else if (w_launch) begin
      r_csum <= 8'd0;
    end else if (w_data_take) begin
      r_csum <= r_csum ^ byte_in;
    end
  end
`endif

  assign wr_en   = w_word_ready;
  assign wr_addr = r_wr_addr;
  assign wr_data = w_word;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Purpose : Self-checking bench for imem_loader. Streams are built from word
//           lists; expected writes are word i at byte address 4*i, and the
//           expected outcome follows from the count limit and checksum rule.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ROWS_TB = 512;
  localparam int WAIT_MAX = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] words[$];
  logic [31:0] ref_data[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  // Write monitor: records every strobe seen mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; one byte transfers per call.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (byte_ready !== 1'b1 && t < WAIT_MAX) begin
      @(negedge clk);
      t++;
    end
    if (t >= WAIT_MAX) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int pick_gap(input int gap_max);
    return (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
  endfunction

  // Header, then data bytes of 'words' (low byte first), then the checksum
  // when enabled. corrupt flips bit 0 of the checksum.
  task automatic send_stream(input int n, input int gap_max, input bit corrupt);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [31:0] nv;
    cs = 8'd0;
    nv = n;
    send_byte(nv[7:0], pick_gap(gap_max));
    send_byte(nv[15:8], pick_gap(gap_max));
    if (n <= ROWS_TB) begin
      for (int i = 0; i < n; i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) begin
          cs = cs ^ w[8*k +: 8];
          send_byte(w[8*k +: 8], pick_gap(gap_max));
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(corrupt ? (cs ^ 8'h01) : cs, pick_gap(gap_max));
`endif
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_load(input string tag, input int n, input bit exp_err);
    int nw;
    nw = exp_err ? 0 : n;
    check({tag, " wr_count"}, q_addr.size(), nw);
    for (int i = 0; i < nw && i < q_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), q_addr[i], 32'(i * 4));
      check($sformatf("%s data[%0d]", tag, i), q_data[i], words[i]);
    end
    check({tag, " done"},       {31'd0, done},       {31'd0, ~exp_err});
    check({tag, " error"},      {31'd0, error},      {31'd0, exp_err});
    check({tag, " cpu_hold"},   {31'd0, cpu_hold},   {31'd0, exp_err});
    check({tag, " byte_ready"}, {31'd0, byte_ready}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, " wr_en"},      {31'd0, wr_en},      32'd0);
    check({tag, " wr_addr"},    wr_addr,             32'd0);
    check({tag, " wr_data"},    wr_data,             32'd0);
    check({tag, " cpu_hold"},   {31'd0, cpu_hold},   32'd1);
    check({tag, " done"},       {31'd0, done},       32'd0);
    check({tag, " error"},      {31'd0, error},      32'd0);
  endtask

  function automatic void clear_log();
    q_addr.delete();
    q_data.delete();
  endfunction

  function automatic void random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom());
  endfunction

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Step 1: reset values.
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("idle byte_ready", {31'd0, byte_ready}, 32'd0);

    // Step 2: directed two-word stream.
    words = '{32'h12345678, 32'hDEADBEEF};
    clear_log();
    pulse_start();
    send_stream(2, 0, 1'b0);
    check_load("two_word", 2, 1'b0);

    // Step 3: zero-length load finishes with no writes.
    words.delete();
    clear_log();
    pulse_start();
    send_stream(0, 0, 1'b0);
    check_load("zero_len", 0, 1'b0);

    // Step 4: full ROWS load.
    random_words(ROWS_TB);
    clear_log();
    pulse_start();
    send_stream(ROWS_TB, 0, 1'b0);
    check_load("full", ROWS_TB, 1'b0);
    if (q_addr.size() > 0) check("full last_addr", q_addr[q_addr.size()-1], 32'h7FC);

    // Step 5: one word too many is rejected after the length bytes.
    clear_log();
    pulse_start();
    send_stream(ROWS_TB + 1, 0, 1'b0);
    check_load("overlen", ROWS_TB + 1, 1'b1);

    // Step 6: gapless vs random-gap 3-word stream.
    random_words(3);
    clear_log();
    pulse_start();
    send_stream(3, 0, 1'b0);
    check_load("gapless", 3, 1'b0);
    ref_data = q_data;
    clear_log();
    pulse_start();
    send_stream(3, 5, 1'b0);
    check_load("gapped", 3, 1'b0);
    for (int i = 0; i < 3 && i < q_data.size() && i < ref_data.size(); i++)
      check($sformatf("gap_vs_nogap[%0d]", i), q_data[i], ref_data[i]);

    // Step 7: start during DATA is ignored.
    random_words(2);
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 8; b++) begin
      logic [31:0] w;
      w = words[b / 4];
      if (b == 5) start = 1'b1;
      send_byte(w[8*(b%4) +: 8], 0);
      start = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(words[0][7:0] ^ words[0][15:8] ^ words[0][23:16] ^ words[0][31:24] ^
              words[1][7:0] ^ words[1][15:8] ^ words[1][23:16] ^ words[1][31:24], 0);
`endif
    repeat (3) @(negedge clk);
    check_load("start_in_data", 2, 1'b0);

    // Step 8: start in DONE re-asserts hold and restarts at address 0.
    pulse_start();
    check("restart cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("restart done",       {31'd0, done},       32'd0);
    check("restart byte_ready", {31'd0, byte_ready}, 32'd1);
    random_words(2);
    clear_log();
    send_stream(2, 0, 1'b0);
    check_load("restart", 2, 1'b0);

    // Step 9: reset after the sixth data byte abandons the load.
    random_words(2);
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 6; b++) begin
      logic [31:0] w;
      w = words[b / 4];
      send_byte(w[8*(b%4) +: 8], 0);
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    check("midload wr_count", q_addr.size(), 32'd1);
    if (q_data.size() > 0) check("midload data[0]", q_data[0], words[0]);
    reset_n = 1'b1;
    @(negedge clk);
    random_words(1);
    clear_log();
    pulse_start();
    send_stream(1, 0, 1'b0);
    check_load("after_reset", 1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Step 10: checksum pass (0F) and corrupted checksum (0E).
    words = '{32'h08040201};
    clear_log();
    pulse_start();
    send_stream(1, 0, 1'b0);
    check_load("csum_ok", 1, 1'b0);
    clear_log();
    pulse_start();
    send_stream(1, 0, 1'b1);
    check("csum_bad error",    {31'd0, error},    32'd1);
    check("csum_bad cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("csum_bad done",     {31'd0, done},     32'd0);
    check("csum_bad wr_count", q_addr.size(),     32'd1);
`else
    // Step 10: the same data without a trailing checksum byte completes.
    words = '{32'h08040201};
    clear_log();
    pulse_start();
    send_stream(1, 0, 1'b0);
    check_load("no_csum", 1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: the program loader that fills the 512-word instruction store before the core starts fetching.
- Accepts a byte stream over a valid/ready handshake from a host link (UART receiver or testbench).
- Assembles little-endian 32-bit words and issues one word write per assembled word, at sequential word addresses starting at 0.
- Holds the core in reset until the load completes, then releases it.

Parameters:
- ROWS, 32'h00000200, number of instruction-memory words; maximum loadable word count.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; begins a new load from IDLE, DONE or ERROR; ignored while loading.
- Byte_in  input  8  stream byte.
- Byte_valid  input  1  Byte_in is valid this cycle.
- Byte_ready  output  1  loader accepts Byte_in; a byte transfers when Byte_valid and Byte_ready are both high on a rising edge.
- Wr_en  output  1  one-cycle instruction-memory write strobe.
- Wr_addr  output  32  byte address of the write; word-aligned, so bits [1:0] = 0.
- Wr_data  output  32  assembled instruction word.
- Cpu_hold  output  1  holds the core in reset while high.
- Done  output  1  load completed successfully; level output.
- Error  output  1  load aborted; level output.

Behaviour:
- Reset values: Byte_ready=0, Wr_en=0, Wr_addr=0, Wr_data=0, Cpu_hold=1, Done=0, Error=0. State=IDLE, all counters 0.
- Reset asserted mid-load: the partial load is abandoned, with no further writes. Words already written stay in memory.
- Stream format: 2-byte word count N (low byte first), then N words of 4 bytes each, least-significant byte first. With CHECKSUM_EN, one trailing checksum byte follows.
- States and transitions:
  - IDLE: Byte_ready=0. Start -> LEN_LO; Start also clears Done, Error, the byte index, the word counter and Wr_addr.
  - LEN_LO: Byte_ready=1. On transfer, latch N[7:0] -> LEN_HI.
  - LEN_HI: Byte_ready=1. On transfer, latch N[15:8], then branch:
    - N > ROWS -> ERROR.
    - N = 0 -> CHK if CHECKSUM_EN, else DONE.
    - otherwise -> DATA.
  - DATA: Byte_ready=1.
    - 2-bit byte index selects the word lane: byte 0 -> bits [7:0] ... byte 3 -> bits [31:24].
    - Transfer of byte 3: Wr_data is loaded with the full word and Wr_en=1 in the next cycle, with Wr_addr = word_count*4.
    - In the cycle after that strobe, Wr_addr increments by 4.
    - After the Nth word's transfer -> CHK if CHECKSUM_EN, else DONE.
    - The trailing Wr_en pulse still occurs after leaving DATA.
  - CHK: Byte_ready=1. On transfer, compare with the checksum: match -> DONE, mismatch -> ERROR.
  - DONE: Byte_ready=0, Done=1, Cpu_hold=0. Start -> LEN_LO and re-asserts Cpu_hold.
  - ERROR: Byte_ready=0, Error=1, Cpu_hold=1. Start -> LEN_LO.
- Throughput: one byte per cycle sustained. Wr_en is at most one pulse per 4 cycles. No back-pressure is applied during DATA.
- Byte_valid low: no state change; stalls of any length are permitted between bytes.
- Cpu_hold falls in the same cycle Done rises. This is never before the final Wr_en has been issued.
- Word counter width is 16 bits. Wr_addr never exceeds (ROWS-1)*4 because N > ROWS is rejected.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - CHK state is present.
  - Running 8-bit XOR of all data bytes, excluding the length bytes, cleared on Start.
  - Trailing byte compared against it: mismatch -> ERROR, Cpu_hold stays 1. Words already written are not erased.
- Undefined: no CHK state and no checksum logic; the stream ends after the last data byte.

Decomposition:
- Shared package (imem_pkg): ROWS default, state enum (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR), byte-lane constants.
- One natural sub-module: imem_word_assembler. It covers the byte index, lane shift register and word-ready pulse, and is reusable for a future data-memory loader.
- The FSM, counters and checksum stay in the top level.

Test Plan:
- Reset, Start, stream 02 00 78 56 34 12 EF BE AD DE -> two Wr_en pulses:
  - addr 0x0 data 0x12345678
  - addr 0x4 data 0xDEADBEEF
  - then Done=1, Cpu_hold=0.
- N=0x0200 (ROWS) full load -> 512 writes, last addr 0x7FC, Done=1. N=0x0201 -> Error=1 after LEN_HI, zero Wr_en, Cpu_hold=1.
- Random 0-5 cycle Byte_valid gaps on a 3-word stream -> identical writes to the gapless run; Byte_ready=0 in IDLE/DONE.
- Assert Reset_n low after the 6th data byte -> all outputs at reset values, no further Wr_en. Restart with a 1-word stream -> write to addr 0x0.
- CHECKSUM_EN, stream 01 00 01 02 04 08 0F -> Done. Same stream with trailing 0E -> Error=1, Cpu_hold=1.
- Start pulsed during DATA -> ignored, load completes normally. Start in DONE -> Cpu_hold=1, Done=0, new load writes from addr 0x0.
